// File: rtl/jenc_pkg.sv
// Shared constants and helpers for the encoder frame parser.
// Default field offsets and lengths, field descriptor type, mirror constant.
package jenc_pkg;

  localparam int RAW_BITS_DEF     = 14;
  localparam int USECS_OFS_DEF    = 4;
  localparam int ANGLE_OFS_DEF    = 16;
  localparam int VEL_OFS_DEF      = 20;
  localparam int RAW_OFS_DEF      = 32;
  localparam int MIN_LEN_DEF      = 34;
  localparam int MAX_LEN_DEF      = 64;
  localparam int CNT_W_DEF        = 16;
  localparam int STALE_CYCLES_DEF = 100000;

  typedef struct packed {
    logic [7:0] ofs;
    logic [2:0] nbytes;
  } field_desc_t;

  // All-ones value of the encoder resolution; mirrored count = this - raw.
  function automatic logic [31:0] mirror_const(input int raw_bits);
    return (32'd1 << raw_bits) - 32'd1;
  endfunction

endpackage

// File: rtl/jenc_frame_parser_if.sv
// Byte stream from the encoder-link receiver: one byte per cycle while rxdv is high.
interface jenc_frame_parser_if;
  logic [7:0] rxd;
  logic       rxdv;

  modport master (output rxd, output rxdv);
  modport slave  (input  rxd, input  rxdv);
endinterface

// File: rtl/jenc_field_capture.sv
// Shadow register for one little-endian field: byte at idx == OFS+k lands in lane k.
module jenc_field_capture #(
  parameter int OFS    = 0,
  parameter int NBYTES = 4
) (
  input  logic                  c,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [7:0]            idx,
  input  logic [7:0]            rxd,
  output logic [8*NBYTES-1:0]   value
);

  always_ff @(posedge c) begin
    if (!rst_n) begin
      value <= '0;
    end else if (we) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (int'(idx) == OFS + k) value[8*k +: 8] <= rxd;
      end
    end
  end

endmodule

// File: rtl/jenc_frame_parser.sv
// Encoder frame field extractor with length-checked atomic commit at end of frame.
// Optional macro JENC_STALE_TIMEOUT_EN adds the STALE_CYCLES parameter and stale output.
module jenc_frame_parser
  import jenc_pkg::*;
#(
  parameter int RAW_BITS  = RAW_BITS_DEF,
  parameter int USECS_OFS = USECS_OFS_DEF,
  parameter int ANGLE_OFS = ANGLE_OFS_DEF,
  parameter int VEL_OFS   = VEL_OFS_DEF,
  parameter int RAW_OFS   = RAW_OFS_DEF,
  parameter int MIN_LEN   = MIN_LEN_DEF,
  parameter int MAX_LEN   = MAX_LEN_DEF,
  parameter int CNT_W     = CNT_W_DEF
`ifdef JENC_STALE_TIMEOUT_EN
  , parameter int STALE_CYCLES = STALE_CYCLES_DEF
`endif
) (
  input  logic               c,
  input  logic               rst_n,
  jenc_frame_parser_if.slave rx,
  input  logic               direction,
  output logic [31:0]        enc_usecs,
  output logic [31:0]        enc_angle,
  output logic [31:0]        enc_vel,
  output logic [15:0]        enc_raw,
  output logic               frame_valid,
  output logic [CNT_W-1:0]   good_cnt,
  output logic [CNT_W-1:0]   bad_cnt
`ifdef JENC_STALE_TIMEOUT_EN
  , output logic             stale
`endif
);

  localparam logic [15:0] RAW_MASK = 16'(mirror_const(RAW_BITS));

  logic        armed;
  logic        rxdv_q;
  logic [7:0]  idx;
  logic        byte_we;
  logic        eof;
  logic        len_ok;
  logic        commit;
  logic [31:0] usecs_sh;
  logic [31:0] angle_sh;
  logic [31:0] vel_sh;
  logic [15:0] raw_sh;
  logic [15:0] raw_m;

  // A frame already running when reset releases is ignored until rxdv drops.
  assign byte_we = rx.rxdv & armed;
  assign eof     = rxdv_q & ~rx.rxdv;
  assign len_ok  = (idx >= 8'(MIN_LEN)) && (idx <= 8'(MAX_LEN)) && (idx != 8'hFF);
  assign commit  = eof & len_ok;
  assign raw_m   = raw_sh & RAW_MASK;

  jenc_field_capture #(.OFS(USECS_OFS), .NBYTES(4)) u_usecs (
    .c(c), .rst_n(rst_n), .we(byte_we), .idx(idx), .rxd(rx.rxd), .value(usecs_sh));
  jenc_field_capture #(.OFS(ANGLE_OFS), .NBYTES(4)) u_angle (
    .c(c), .rst_n(rst_n), .we(byte_we), .idx(idx), .rxd(rx.rxd), .value(angle_sh));
  jenc_field_capture #(.OFS(VEL_OFS), .NBYTES(4)) u_vel (
    .c(c), .rst_n(rst_n), .we(byte_we), .idx(idx), .rxd(rx.rxd), .value(vel_sh));
  jenc_field_capture #(.OFS(RAW_OFS), .NBYTES(2)) u_raw (
    .c(c), .rst_n(rst_n), .we(byte_we), .idx(idx), .rxd(rx.rxd), .value(raw_sh));

  always_ff @(posedge c) begin
    if (!rst_n) begin
      armed       <= ~rx.rxdv;
      rxdv_q      <= 1'b0;
      idx         <= '0;
      enc_usecs   <= '0;
      enc_angle   <= '0;
      enc_vel     <= '0;
      enc_raw     <= '0;
      frame_valid <= 1'b0;
      good_cnt    <= '0;
      bad_cnt     <= '0;
    end else begin
      frame_valid <= 1'b0;
      rxdv_q      <= byte_we;
      if (!rx.rxdv) armed <= 1'b1;

      if (byte_we) begin
        if (idx != 8'hFF) idx <= idx + 8'd1;
      end else begin
        idx <= '0;
      end

      if (commit) begin
        enc_usecs   <= usecs_sh;
        enc_angle   <= angle_sh;
        enc_vel     <= vel_sh;
        enc_raw     <= direction ? (RAW_MASK - raw_m) : raw_m;
        frame_valid <= 1'b1;
        good_cnt    <= good_cnt + 1'b1;
      end else if (eof) begin
        bad_cnt     <= bad_cnt + 1'b1;
      end
    end
  end

`ifdef JENC_STALE_TIMEOUT_EN
  localparam int                 STALE_W   = $clog2(STALE_CYCLES + 1);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(STALE_CYCLES);

  logic [STALE_W-1:0] stale_cnt;

  always_ff @(posedge c) begin
    if (!rst_n) begin
      stale_cnt <= STALE_MAX;
      stale     <= 1'b1;
    end else if (commit) begin
      stale_cnt <= '0;
      stale     <= 1'b0;
    end else if (stale_cnt != STALE_MAX) begin
      stale_cnt <= stale_cnt + 1'b1;
      stale     <= (stale_cnt + 1'b1 == STALE_MAX);
    end
  end
`endif

endmodule

// File: tb/tb_jenc_frame_parser.sv
// Directed bench for jenc_frame_parser with a scoreboard of expected commits.
module tb_jenc_frame_parser;

  localparam int STALE_N = 50;

  logic        c = 1'b0;
  logic        rst_n;
  logic        direction;
  logic [31:0] enc_usecs, enc_angle, enc_vel;
  logic [15:0] enc_raw;
  logic        frame_valid;
  logic [15:0] good_cnt, bad_cnt;
`ifdef JENC_STALE_TIMEOUT_EN
  logic        stale;
`endif

  jenc_frame_parser_if rx_if ();

`ifdef JENC_STALE_TIMEOUT_EN
  jenc_frame_parser #(.STALE_CYCLES(STALE_N)) dut (
`else
  jenc_frame_parser dut (
`endif
    .c(c), .rst_n(rst_n), .rx(rx_if.slave), .direction(direction),
    .enc_usecs(enc_usecs), .enc_angle(enc_angle), .enc_vel(enc_vel), .enc_raw(enc_raw),
    .frame_valid(frame_valid), .good_cnt(good_cnt), .bad_cnt(bad_cnt)
`ifdef JENC_STALE_TIMEOUT_EN
    , .stale(stale)
`endif
  );

  always #5 c = ~c;

  typedef struct {
    logic [31:0] usecs;
    logic [31:0] angle;
    logic [31:0] vel;
    logic [15:0] raw;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          last_fv_cyc = -1;
  logic [15:0] exp_good = 0, exp_bad = 0;
  exp_t        last_exp;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge c) cyc++;

  // Every frame_valid pulse must match the oldest expected commit.
  always @(negedge c) begin
    if (frame_valid === 1'b1) begin
      last_fv_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_frame_valid", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("latency",   64'(cyc), 64'(e.cyc));
        check("enc_usecs", 64'(enc_usecs), 64'(e.usecs));
        check("enc_angle", 64'(enc_angle), 64'(e.angle));
        check("enc_vel",   64'(enc_vel),   64'(e.vel));
        check("enc_raw",   64'(enc_raw),   64'(e.raw));
      end
    end
  end

  function automatic logic [15:0] model_raw(input logic [15:0] r, input logic dir);
    logic [15:0] m;
    m = r & 16'h3FFF;
    return dir ? (16'h3FFF - m) : m;
  endfunction

  // Drives one frame of len bytes; a legal frame pushes its expected commit.
  // rst_at >= 0 pulses rst_n low during that byte while the frame continues.
  task automatic send_frame(input int len, input logic [31:0] us, input logic [31:0] an,
                            input logic [31:0] ve, input logic [15:0] rw, input logic dir,
                            input int rst_at);
    logic [7:0] b;
    logic [31:0] us_v, an_v, ve_v;
    logic [15:0] rw_v;
    int last_cyc;
    us_v = us; an_v = an; ve_v = ve; rw_v = rw;
    direction = dir;
    for (int i = 0; i < len; i++) begin
      @(posedge c); #1;
      b = 8'(i * 7 + 3);
      if (i >= 4  && i < 8)  b = us_v[8*(i-4)  +: 8];
      if (i >= 16 && i < 20) b = an_v[8*(i-16) +: 8];
      if (i >= 20 && i < 24) b = ve_v[8*(i-20) +: 8];
      if (i >= 32 && i < 34) b = rw_v[8*(i-32) +: 8];
      rx_if.rxd  = b;
      rx_if.rxdv = 1'b1;
      rst_n      = (i == rst_at) ? 1'b0 : 1'b1;
      last_cyc   = cyc;
    end
    @(posedge c); #1;
    rx_if.rxdv = 1'b0;
    rst_n      = 1'b1;
    if (rst_at >= 0) begin
      exp_good = 0;
      exp_bad  = 0;
      last_exp = '{usecs: 0, angle: 0, vel: 0, raw: 0, cyc: 0};
    end else if (len >= 34 && len <= 64) begin
      exp_t e;
      e = '{usecs: us, angle: an, vel: ve, raw: model_raw(rw, dir), cyc: last_cyc + 2};
      sb.push_back(e);
      last_exp = e;
      exp_good++;
    end else begin
      exp_bad++;
    end
  endtask

  task automatic check_state(input string tag);
    repeat (3) @(negedge c);
    check({tag, "_good_cnt"}, 64'(good_cnt), 64'(exp_good));
    check({tag, "_bad_cnt"},  64'(bad_cnt),  64'(exp_bad));
    check({tag, "_usecs_hold"}, 64'(enc_usecs), 64'(last_exp.usecs));
    check({tag, "_raw_hold"},   64'(enc_raw),   64'(last_exp.raw));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rx_if.rxd = 8'h00; rx_if.rxdv = 1'b0; direction = 1'b0;
    last_exp = '{usecs: 0, angle: 0, vel: 0, raw: 0, cyc: 0};
    repeat (3) @(posedge c);
    #1 rst_n = 1'b1;
    @(negedge c);
    check("rst_usecs", 64'(enc_usecs), 64'd0);
    check("rst_raw",   64'(enc_raw),   64'd0);
    check("rst_fv",    64'(frame_valid), 64'd0);
    check("rst_good",  64'(good_cnt),  64'd0);
    check("rst_bad",   64'(bad_cnt),   64'd0);
`ifdef JENC_STALE_TIMEOUT_EN
    check("rst_stale", 64'(stale), 64'd1);
`endif

    send_frame(34, 32'h12345678, 32'h1, 32'hFFFFFFFF, 16'h1234, 1'b0, -1);
    check_state("f1");
`ifdef JENC_STALE_TIMEOUT_EN
    check("stale_clear", 64'(stale), 64'd0);
`endif
    send_frame(34, 32'h12345678, 32'h1, 32'hFFFFFFFF, 16'h1234, 1'b1, -1);
    check_state("mirror");
    check("mirror_val", 64'(enc_raw), 64'h2DCB);

    send_frame(20, 32'hAAAA5555, 32'h2, 32'h3, 16'h0777, 1'b0, -1);
    check_state("short20");
    send_frame(70, 32'hBBBB6666, 32'h4, 32'h5, 16'h0888, 1'b0, -1);
    check_state("long70");
    send_frame(33, 32'hCCCC7777, 32'h6, 32'h7, 16'h0999, 1'b0, -1);
    check_state("len33");
    send_frame(65, 32'hCCCC8888, 32'h8, 32'h9, 16'h0AAA, 1'b0, -1);
    check_state("len65");
    send_frame(260, 32'hDDDD9999, 32'hA, 32'hB, 16'h0BBB, 1'b0, -1);
    check_state("len260");
    send_frame(64, 32'h0BADF00D, 32'h80000000, 32'h7FFFFFFF, 16'hF234, 1'b1, -1);
    check_state("len64");

    send_frame(40, 32'h11112222, 32'hC, 32'hD, 16'h0123, 1'b0, -1);
    send_frame(34, 32'hDEADBEEF, 32'hE, 32'hF, 16'h3FFF, 1'b0, -1);
    check_state("b2b");
    check("b2b_usecs", 64'(enc_usecs), 64'hDEADBEEF);

    send_frame(34, 32'h55555555, 32'h10, 32'h11, 16'h0456, 1'b0, 10);
    check_state("rst_mid");
`ifdef JENC_STALE_TIMEOUT_EN
    check("rst_mid_stale", 64'(stale), 64'd1);
`endif
    send_frame(34, 32'h66666666, 32'h12, 32'h13, 16'h0567, 1'b1, -1);
    check_state("after_rst");

`ifdef JENC_STALE_TIMEOUT_EN
    for (int n = 0; n < 200 && cyc < last_fv_cyc + STALE_N - 1; n++) @(negedge c);
    check("stale_wait_cyc", 64'(cyc), 64'(last_fv_cyc + STALE_N - 1));
    check("stale_before", 64'(stale), 64'd0);
    @(negedge c);
    check("stale_after", 64'(stale), 64'd1);
`endif

    repeat (5) @(negedge c);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
